segre_mem_stage: RTL and testbench
==================================

// Module: segre_mem_stage
// PURPOSE
//  Memory stage of the Segre pipeline; consumes the registered EX stage outputs.
//  Loads and stores go to the data memory over a req/gnt/rvalid handshake, with
//  byte lanes aligned and load data sign/zero extended. Produces registered WB outputs.
//  Raises mem_stall_o while a memory access is outstanding, which freezes EX and the
//  upstream stages through their hazard_i.
// PARAMETERS
//  WORD_SIZE  32  data/address width
//  REG_SIZE   5   register file address width
// PORTS
//  clk_i             in   1          clock
//  rsn_i             in   1          reset, asynchronous, active-low
//  alu_res_i         in   WORD_SIZE  ALU result / effective address from EX
//  rf_we_i           in   1          register write enable from EX
//  rf_waddr_i        in   REG_SIZE   destination register
//  rf_st_data_i      in   WORD_SIZE  store data
//  memop_type_i      in   memop_data_type_e  BYTE / HALF / WORD
//  memop_rd_i        in   1          load
//  memop_wr_i        in   1          store
//  memop_sign_ext_i  in   1          1 = sign-extend load, 0 = zero-extend
//  dmem_req_o        out  1          memory request
//  dmem_we_o         out  1          1 = write
//  dmem_addr_o       out  WORD_SIZE  word address; bits [1:0] always 0
//  dmem_be_o         out  4          byte enables
//  dmem_wdata_o      out  WORD_SIZE  lane-replicated store data
//  dmem_gnt_i        in   1          request accepted
//  dmem_rvalid_i     in   1          load data valid
//  dmem_rdata_i      in   WORD_SIZE  load data
//  rf_we_o           out  1          WB write enable
//  rf_waddr_o        out  REG_SIZE   WB destination
//  rf_wdata_o        out  WORD_SIZE  WB data
//  mem_stall_o       out  1          stall upstream (= state != IDLE)
//  misaligned_o      out  1          1-cycle pulse: misaligned access dropped
// BEHAVIOUR
//  Reset (async):
//   - state = IDLE; all outputs 0, including dmem_req_o.
//   - Reset mid-access abandons it; the request drops immediately.
//  FSM IDLE/REQ/WAIT. Inputs are sampled only in IDLE; they are ignored while stalled.
//  IDLE, non-memop:
//   - next edge: rf_we_o = rf_we_i, rf_waddr_o = rf_waddr_i, rf_wdata_o = alu_res_i.
//   - latency 1.
//  IDLE, memop (rd has priority if rd and wr are both set):
//   - capture op and go to REQ; rf_we_o = 0 next cycle.
//  Misaligned access (HALF with a[0]=1, or WORD with a!=0; a = alu_res_i[1:0]):
//   - no request; stay IDLE; rf_we_o = 0; misaligned_o = 1 for one cycle.
//  REQ:
//   - dmem_req_o = 1; addr/we/be/wdata are registered and held stable until dmem_gnt_i.
//   - gnt & store: return to IDLE, rf_we_o = 0.
//   - gnt & load: go to WAIT.
//   - dmem_rvalid_i is ignored in REQ.
//  WAIT:
//   - dmem_req_o = 0.
//   - on dmem_rvalid_i: rf_we_o = rf_we captured, rf_wdata_o = extended data; go to IDLE.
//  Byte lanes:
//   - BYTE: be = 4'b0001<<a, wdata = {4{st[7:0]}}.
//   - HALF: be = 4'b0011<<a, wdata = {2{st[15:0]}}.
//   - WORD: be = 4'b1111.
//  Load extract:
//   - BYTE = rdata[8a+:8], HALF = rdata[8a+:16], extended to 32 bits per memop_sign_ext.
//  Stall and bubbles:
//   - rf_we_o = 0 on every stall cycle except the completion edge.
//   - The instruction held upstream is accepted in the IDLE cycle after completion.
//   - No instruction is duplicated or lost.
// TESTING
//  - ADD, alu_res=0x1234 -> next cycle rf_we_o=1, rf_wdata_o=0x1234, mem_stall_o stays 0.
//  - LB addr 0x103, sext=1, gnt after 2 cycles, rdata=0x80FFFFFF
//    -> be=4'b1000, addr=0x100, rf_wdata_o=0xFFFFFF80.
//  - SH addr 0x202, st=0xABCD, gnt same cycle
//    -> be=4'b1100, wdata=0xABCDABCD, rf_we_o=0, stall for exactly 1 cycle.
//  - LW addr 0x005 -> misaligned_o=1 for 1 cycle, dmem_req_o never asserted.
//  - LHU addr 0x002, rdata=0x8001xxxx; rvalid 3 cycles after gnt
//    -> rf_wdata_o=0x00008001; next instruction written back exactly once.
//  - rsn_i low while in WAIT -> all outputs 0 asynchronously; a later rvalid is ignored.

Source files
------------

// File: rtl/segre_mem_stage.sv
// Segre pipeline memory stage.
// Takes the registered EX outputs and either passes ALU results through to WB
// or runs a single data-memory access over a req/gnt/rvalid handshake.
// While an access is in flight mem_stall_o holds the upstream stages, so the
// next instruction waits on the EX outputs until this stage is back in IDLE.
module segre_mem_stage #(
    parameter int WORD_SIZE = 32,
    parameter int REG_SIZE  = 5
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic [WORD_SIZE-1:0] alu_res_i,
    input  logic                 rf_we_i,
    input  logic [REG_SIZE-1:0]  rf_waddr_i,
    input  logic [WORD_SIZE-1:0] rf_st_data_i,
    input  logic [1:0]           memop_type_i,
    input  logic                 memop_rd_i,
    input  logic                 memop_wr_i,
    input  logic                 memop_sign_ext_i,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic [WORD_SIZE-1:0] dmem_addr_o,
    output logic [3:0]           dmem_be_o,
    output logic [WORD_SIZE-1:0] dmem_wdata_o,
    input  logic                 dmem_gnt_i,
    input  logic                 dmem_rvalid_i,
    input  logic [WORD_SIZE-1:0] dmem_rdata_i,
    output logic                 rf_we_o,
    output logic [REG_SIZE-1:0]  rf_waddr_o,
    output logic [WORD_SIZE-1:0] rf_wdata_o,
    output logic                 mem_stall_o,
    output logic                 misaligned_o
);

    // memop_data_type_e encoding
    localparam logic [1:0] MEMOP_BYTE = 2'b00;
    localparam logic [1:0] MEMOP_HALF = 2'b01;
    localparam logic [1:0] MEMOP_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]           state_q, state_d;
    logic                 dwe_q, dwe_d;
    logic [WORD_SIZE-1:0] daddr_q, daddr_d;
    logic [3:0]           dbe_q, dbe_d;
    logic [WORD_SIZE-1:0] dwdata_q, dwdata_d;
    logic [1:0]           type_q, type_d;
    logic                 sext_q, sext_d;
    logic [1:0]           off_q, off_d;
    logic                 cap_we_q, cap_we_d;
    logic                 rf_we_q, rf_we_d;
    logic [REG_SIZE-1:0]  rf_waddr_q, rf_waddr_d;
    logic [WORD_SIZE-1:0] rf_wdata_q, rf_wdata_d;
    logic                 misal_q, misal_d;

    logic [1:0]           off;
    logic                 is_memop;
    logic                 misal;
    logic [3:0]           be_calc;
    logic [WORD_SIZE-1:0] wdata_calc;
    logic [WORD_SIZE-1:0] ld_shift;
    logic [WORD_SIZE-1:0] ld_ext;

    assign off      = alu_res_i[1:0];
    assign is_memop = memop_rd_i | memop_wr_i;

    // Alignment check, byte enables and lane-replicated store data for the incoming op
    always_comb begin
        misal      = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = rf_st_data_i;
        case (memop_type_i)
            MEMOP_BYTE: begin
                be_calc    = 4'b0001 << off;
                wdata_calc = {(WORD_SIZE/8){rf_st_data_i[7:0]}};
            end
            MEMOP_HALF: begin
                misal      = off[0];
                be_calc    = 4'b0011 << off;
                wdata_calc = {(WORD_SIZE/16){rf_st_data_i[15:0]}};
            end
            default: begin
                misal = (off != 2'b00);
            end
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it
    always_comb begin
        ld_shift = dmem_rdata_i >> {off_q, 3'b000};
        case (type_q)
            MEMOP_BYTE: ld_ext = {{(WORD_SIZE-8){sext_q & ld_shift[7]}}, ld_shift[7:0]};
            MEMOP_HALF: ld_ext = {{(WORD_SIZE-16){sext_q & ld_shift[15]}}, ld_shift[15:0]};
            default:    ld_ext = dmem_rdata_i;
        endcase
    end

    // Next-state logic: inputs are only looked at in IDLE, so a stalled EX is ignored
    always_comb begin
        state_d    = state_q;
        dwe_d      = dwe_q;
        daddr_d    = daddr_q;
        dbe_d      = dbe_q;
        dwdata_d   = dwdata_q;
        type_d     = type_q;
        sext_d     = sext_q;
        off_d      = off_q;
        cap_we_d   = cap_we_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        misal_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_memop) begin
                    if (misal) begin
                        misal_d = 1'b1;
                    end else begin
                        state_d    = ST_REQ;
                        dwe_d      = ~memop_rd_i;
                        daddr_d    = {alu_res_i[WORD_SIZE-1:2], 2'b00};
                        dbe_d      = be_calc;
                        dwdata_d   = wdata_calc;
                        type_d     = memop_type_i;
                        sext_d     = memop_sign_ext_i;
                        off_d      = off;
                        cap_we_d   = rf_we_i;
                        rf_waddr_d = rf_waddr_i;
                    end
                end else begin
                    rf_we_d    = rf_we_i;
                    rf_waddr_d = rf_waddr_i;
                    rf_wdata_d = alu_res_i;
                end
            end
            ST_REQ: begin
                if (dmem_gnt_i) begin
                    state_d = dwe_q ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid_i) begin
                    rf_we_d    = cap_we_q;
                    rf_wdata_d = ld_ext;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything and abandons any access
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q    <= ST_IDLE;
            dwe_q      <= 1'b0;
            daddr_q    <= '0;
            dbe_q      <= 4'b0000;
            dwdata_q   <= '0;
            type_q     <= MEMOP_BYTE;
            sext_q     <= 1'b0;
            off_q      <= 2'b00;
            cap_we_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            misal_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dwe_q      <= dwe_d;
            daddr_q    <= daddr_d;
            dbe_q      <= dbe_d;
            dwdata_q   <= dwdata_d;
            type_q     <= type_d;
            sext_q     <= sext_d;
            off_q      <= off_d;
            cap_we_q   <= cap_we_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            misal_q    <= misal_d;
        end
    end

    assign dmem_req_o   = (state_q == ST_REQ);
    assign dmem_we_o    = dwe_q;
    assign dmem_addr_o  = daddr_q;
    assign dmem_be_o    = dbe_q;
    assign dmem_wdata_o = dwdata_q;
    assign rf_we_o      = rf_we_q;
    assign rf_waddr_o   = rf_waddr_q;
    assign rf_wdata_o   = rf_wdata_q;
    assign mem_stall_o  = (state_q != ST_IDLE);
    assign misaligned_o = misal_q;

endmodule

// File: tb/tb_segre_mem_stage.sv
// Bench for segre_mem_stage: directed scenarios followed by a randomized
// instruction stream checked against transaction-level expectation queues.
module tb_segre_mem_stage;

    localparam logic [1:0] T_B = 2'd0;
    localparam logic [1:0] T_H = 2'd1;
    localparam logic [1:0] T_W = 2'd2;
    localparam int NI = 200;

    logic        clk = 1'b0;
    logic        rsn;
    logic [31:0] alu, st, rdata;
    logic        rfwe, rd, wr, sx, gnt, rv;
    logic [4:0]  waddr;
    logic [1:0]  typ;
    logic        req_o, we_o, rfwe_o, stall_o, mis_o;
    logic [31:0] addr_o, wdata_o, rfwdata_o;
    logic [3:0]  be_o;
    logic [4:0]  rfwaddr_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    segre_mem_stage #(.WORD_SIZE(32), .REG_SIZE(5)) dut (
        .clk_i(clk), .rsn_i(rsn), .alu_res_i(alu), .rf_we_i(rfwe), .rf_waddr_i(waddr),
        .rf_st_data_i(st), .memop_type_i(typ), .memop_rd_i(rd), .memop_wr_i(wr),
        .memop_sign_ext_i(sx), .dmem_req_o(req_o), .dmem_we_o(we_o), .dmem_addr_o(addr_o),
        .dmem_be_o(be_o), .dmem_wdata_o(wdata_o), .dmem_gnt_i(gnt), .dmem_rvalid_i(rv),
        .dmem_rdata_i(rdata), .rf_we_o(rfwe_o), .rf_waddr_o(rfwaddr_o), .rf_wdata_o(rfwdata_o),
        .mem_stall_o(stall_o), .misaligned_o(mis_o)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic setin(input logic [31:0] a, input logic we, input logic [4:0] wa,
                         input logic [31:0] s, input logic [1:0] t, input logic r,
                         input logic w, input logic x);
        alu = a; rfwe = we; waddr = wa; st = s; typ = t; rd = r; wr = w; sx = x;
    endtask

    task automatic nop();
        setin(32'h0, 1'b0, 5'd0, 32'h0, T_W, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [31:0] alu, st, rdata;
        logic        we, rd, wr, sx;
        logic [4:0]  waddr;
        logic [1:0]  typ;
    } instr_t;

    typedef struct {
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  be;
        logic        we;
    } mexp_t;

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] data;
    } wb_t;

    instr_t prog[NI];
    mexp_t  memq[$];
    wb_t    wbq[$];
    int     mis_exp = 0;
    int     mis_seen = 0;

    // Reference load extraction written with plain arithmetic
    function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] t,
                                             input logic [1:0] a, input logic x);
        logic [31:0] v;
        v = d >> (8 * a);
        if (t == T_B) begin
            v = v % 256;
            if (x && v >= 128) v = v + 32'hFFFFFF00;
        end else if (t == T_H) begin
            v = v % 65536;
            if (x && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    task automatic build_prog();
        int     kind;
        logic   bad;
        mexp_t  m;
        wb_t    w;
        for (int i = 0; i < NI; i++) begin
            kind = $urandom_range(0, 9);
            prog[i].alu   = $urandom;
            prog[i].st    = $urandom;
            prog[i].rdata = $urandom;
            prog[i].we    = ($urandom_range(0, 4) != 0);
            prog[i].waddr = 5'($urandom);
            prog[i].typ   = 2'($urandom_range(0, 2));
            prog[i].sx    = 1'($urandom);
            prog[i].rd    = (kind >= 4 && kind <= 6) || kind == 9;
            prog[i].wr    = (kind >= 7);
            if (!(prog[i].rd || prog[i].wr)) begin
                if (prog[i].we) begin
                    w.waddr = prog[i].waddr; w.data = prog[i].alu;
                    wbq.push_back(w);
                end
                continue;
            end
            if ($urandom_range(0, 1) == 1) prog[i].alu[1:0] = 2'b00;
            bad = (prog[i].typ == T_H && prog[i].alu[0]) ||
                  (prog[i].typ == T_W && prog[i].alu[1:0] != 2'b00);
            if (bad) begin
                mis_exp++;
                continue;
            end
            m.addr  = prog[i].alu - (prog[i].alu % 4);
            m.we    = !prog[i].rd;
            m.rdata = prog[i].rdata;
            if (prog[i].typ == T_B) begin
                m.be    = 4'(1 << prog[i].alu[1:0]);
                m.wdata = (prog[i].st % 256) * 32'h01010101;
            end else if (prog[i].typ == T_H) begin
                m.be    = 4'(3 << prog[i].alu[1:0]);
                m.wdata = (prog[i].st % 65536) * 32'h00010001;
            end else begin
                m.be    = 4'hF;
                m.wdata = prog[i].st;
            end
            memq.push_back(m);
            if (prog[i].rd && prog[i].we) begin
                w.waddr = prog[i].waddr;
                w.data  = ref_load(prog[i].rdata, prog[i].typ, prog[i].alu[1:0], prog[i].sx);
                wbq.push_back(w);
            end
        end
    endtask

    task automatic present(input int i);
        if (i < NI) setin(prog[i].alu, prog[i].we, prog[i].waddr, prog[i].st,
                          prog[i].typ, prog[i].rd, prog[i].wr, prog[i].sx);
        else nop();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, {31'd0, req_o}, 32'd0);
        chk({tag, "_we"}, {31'd0, we_o}, 32'd0);
        chk({tag, "_addr"}, addr_o, 32'd0);
        chk({tag, "_be"}, {28'd0, be_o}, 32'd0);
        chk({tag, "_wdata"}, wdata_o, 32'd0);
        chk({tag, "_rfwe"}, {31'd0, rfwe_o}, 32'd0);
        chk({tag, "_rfwaddr"}, {27'd0, rfwaddr_o}, 32'd0);
        chk({tag, "_rfwdata"}, rfwdata_o, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
        chk({tag, "_mis"}, {31'd0, mis_o}, 32'd0);
    endtask

    initial begin
        int     idx, cyc, gdly, rdly;
        logic   acc, have_req, wait_rv;
        mexp_t  cur;
        wb_t    e;

        rsn = 1'b0; gnt = 1'b0; rv = 1'b0; rdata = 32'h0;
        nop();
        #2;
        chk_all_zero("reset");
        smp();
        rsn = 1'b1;

        // ADD passes straight through with latency 1
        tick(); setin(32'h1234, 1'b1, 5'd3, 32'h0, T_W, 1'b0, 1'b0, 1'b0);
        smp(); chk("add_stall0", {31'd0, stall_o}, 32'd0);
        tick(); nop();
        smp();
        chk("add_we", {31'd0, rfwe_o}, 32'd1);
        chk("add_data", rfwdata_o, 32'h1234);
        chk("add_waddr", {27'd0, rfwaddr_o}, 32'd3);
        chk("add_stall1", {31'd0, stall_o}, 32'd0);

        // LB 0x103 signed, grant on second request cycle, then a held ADD
        tick(); setin(32'h103, 1'b1, 5'd5, 32'h0, T_B, 1'b1, 1'b0, 1'b1);
        tick(); setin(32'h55, 1'b1, 5'd6, 32'h0, T_W, 1'b0, 1'b0, 1'b0);
        smp();
        chk("lb_req", {31'd0, req_o}, 32'd1);
        chk("lb_addr", addr_o, 32'h100);
        chk("lb_be", {28'd0, be_o}, 32'h8);
        chk("lb_we", {31'd0, we_o}, 32'd0);
        chk("lb_stall", {31'd0, stall_o}, 32'd1);
        chk("lb_bubble", {31'd0, rfwe_o}, 32'd0);
        tick(); smp();
        chk("lb_req_hold", {31'd0, req_o}, 32'd1);
        chk("lb_addr_hold", addr_o, 32'h100);
        gnt = 1'b1;
        tick(); gnt = 1'b0;
        smp();
        chk("lb_wait_req", {31'd0, req_o}, 32'd0);
        chk("lb_wait_stall", {31'd0, stall_o}, 32'd1);
        rv = 1'b1; rdata = 32'h80FFFFFF;
        tick(); rv = 1'b0;
        smp();
        chk("lb_wb_we", {31'd0, rfwe_o}, 32'd1);
        chk("lb_wb_addr", {27'd0, rfwaddr_o}, 32'd5);
        chk("lb_wb_data", rfwdata_o, 32'hFFFFFF80);
        chk("lb_done_stall", {31'd0, stall_o}, 32'd0);
        tick(); nop();
        smp();
        chk("lb_next_we", {31'd0, rfwe_o}, 32'd1);
        chk("lb_next_data", rfwdata_o, 32'h55);
        chk("lb_next_addr", {27'd0, rfwaddr_o}, 32'd6);

        // SH 0x202, granted in the first request cycle
        tick(); setin(32'h202, 1'b0, 5'd0, 32'hABCD, T_H, 1'b0, 1'b1, 1'b0);
        tick(); nop(); gnt = 1'b1;
        smp();
        chk("sh_req", {31'd0, req_o}, 32'd1);
        chk("sh_be", {28'd0, be_o}, 32'hC);
        chk("sh_wdata", wdata_o, 32'hABCDABCD);
        chk("sh_addr", addr_o, 32'h200);
        chk("sh_we", {31'd0, we_o}, 32'd1);
        chk("sh_stall", {31'd0, stall_o}, 32'd1);
        tick(); gnt = 1'b0;
        smp();
        chk("sh_stall_end", {31'd0, stall_o}, 32'd0);
        chk("sh_rfwe", {31'd0, rfwe_o}, 32'd0);
        chk("sh_req_end", {31'd0, req_o}, 32'd0);

        // LW 0x005 is misaligned
        tick(); setin(32'h005, 1'b1, 5'd4, 32'h0, T_W, 1'b1, 1'b0, 1'b0);
        tick(); nop();
        smp();
        chk("lw_mis", {31'd0, mis_o}, 32'd1);
        chk("lw_mis_req", {31'd0, req_o}, 32'd0);
        chk("lw_mis_stall", {31'd0, stall_o}, 32'd0);
        chk("lw_mis_rfwe", {31'd0, rfwe_o}, 32'd0);
        tick(); smp();
        chk("lw_mis_pulse", {31'd0, mis_o}, 32'd0);
        chk("lw_mis_req2", {31'd0, req_o}, 32'd0);

        // LHU 0x002, rvalid three cycles after grant, followed by an ADD
        tick(); setin(32'h002, 1'b1, 5'd7, 32'h0, T_H, 1'b1, 1'b0, 1'b0);
        tick(); setin(32'h77, 1'b1, 5'd8, 32'h0, T_W, 1'b0, 1'b0, 1'b0); gnt = 1'b1;
        smp();
        chk("lhu_req", {31'd0, req_o}, 32'd1);
        chk("lhu_be", {28'd0, be_o}, 32'hC);
        chk("lhu_addr", addr_o, 32'h0);
        tick(); gnt = 1'b0;
        smp(); chk("lhu_wait1", {31'd0, stall_o}, 32'd1);
        tick(); smp(); chk("lhu_wait2", {31'd0, stall_o}, 32'd1);
        tick(); rv = 1'b1; rdata = 32'h80015A5A;
        tick(); rv = 1'b0;
        smp();
        chk("lhu_wb_we", {31'd0, rfwe_o}, 32'd1);
        chk("lhu_wb_addr", {27'd0, rfwaddr_o}, 32'd7);
        chk("lhu_wb_data", rfwdata_o, 32'h00008001);
        tick(); nop();
        smp();
        chk("lhu_next_we", {31'd0, rfwe_o}, 32'd1);
        chk("lhu_next_data", rfwdata_o, 32'h77);
        chk("lhu_next_addr", {27'd0, rfwaddr_o}, 32'd8);
        tick(); smp();
        chk("lhu_next_once", {31'd0, rfwe_o}, 32'd0);

        // Reset while waiting for load data
        tick(); setin(32'h40, 1'b1, 5'd9, 32'h0, T_W, 1'b1, 1'b0, 1'b0);
        tick(); nop(); gnt = 1'b1;
        tick(); gnt = 1'b0;
        smp();
        chk("rst_wait_stall", {31'd0, stall_o}, 32'd1);
        #2 rsn = 1'b0;
        #1 chk_all_zero("rst_async");
        smp();
        rsn = 1'b1; rv = 1'b1; rdata = 32'h12345678;
        tick(); rv = 1'b0;
        smp();
        chk("rst_rv_ignored", {31'd0, rfwe_o}, 32'd0);
        chk("rst_rv_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_rv_data", rfwdata_o, 32'd0);

        // Randomized instruction stream with a reactive memory
        build_prog();
        tick();
        idx = 0; present(0);
        have_req = 1'b0; wait_rv = 1'b0; gdly = 0; rdly = 0;
        cur = '{default: '0};
        cyc = 0;
        while (cyc < 6000 && !(idx >= NI && !stall_o && wbq.size() == 0 && memq.size() == 0)) begin
            cyc++;
            smp();
            if (rfwe_o) begin
                if (wbq.size() == 0) begin
                    chk("rnd_wb_extra", {31'd0, rfwe_o}, 32'd0);
                end else begin
                    e = wbq.pop_front();
                    chk("rnd_wb_addr", {27'd0, rfwaddr_o}, {27'd0, e.waddr});
                    chk("rnd_wb_data", rfwdata_o, e.data);
                end
            end
            if (mis_o) mis_seen++;
            gnt = 1'b0; rv = 1'b0;
            if (req_o) begin
                if (!have_req) begin
                    have_req = 1'b1;
                    gdly = $urandom_range(0, 2);
                    if (memq.size() == 0) begin
                        chk("rnd_req_extra", {31'd0, req_o}, 32'd0);
                        cur = '{default: '0};
                    end else begin
                        cur = memq.pop_front();
                        chk("rnd_addr", addr_o, cur.addr);
                        chk("rnd_we", {31'd0, we_o}, {31'd0, cur.we});
                        chk("rnd_be", {28'd0, be_o}, {28'd0, cur.be});
                        if (cur.we) chk("rnd_wdata", wdata_o, cur.wdata);
                    end
                end
                if (gdly == 0) begin
                    gnt = 1'b1;
                    have_req = 1'b0;
                    if (!cur.we) begin
                        wait_rv = 1'b1;
                        rdly = $urandom_range(0, 3);
                    end
                end else begin
                    gdly--;
                    if ($urandom_range(0, 1) == 1) begin
                        rv = 1'b1; rdata = $urandom;
                    end
                end
            end else if (wait_rv) begin
                if (rdly == 0) begin
                    rv = 1'b1; rdata = cur.rdata; wait_rv = 1'b0;
                end else begin
                    rdly--;
                end
            end
            acc = !stall_o;
            tick();
            if (acc && idx < NI) begin
                idx++;
                present(idx);
            end
        end
        chk("rnd_all_issued", idx, NI);
        chk("rnd_wb_left", wbq.size(), 0);
        chk("rnd_mem_left", memq.size(), 0);
        chk("rnd_misaligned", mis_seen, mis_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
